// File: rtl/spi_mux_handoff_ctl.sv
// ============================================================================
// Module   : spi_mux_handoff_ctl
// Brief    : Hands one shared SPI flash mux between the host path and the PFR
//            master once host CS_N has been quiet long enough.
//            Optional forced takeover: define SPI_MUX_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_mux_handoff_ctl #(
    parameter int IDLE_CYCLES    = 16,
    parameter int SETTLE_CYCLES  = 4,
    parameter int RST_CYCLES     = 8,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic       iClk,
    input  logic       iRst,
    input  logic       iPfrReq,
    input  logic       iHostCs_n,
    output logic       oMasterSel,
    output logic       oFlashRst_n,
    output logic       oGrant,
    output logic       oTimeout,
    output logic [2:0] oState
);

    localparam int c_MAX_A = (IDLE_CYCLES > SETTLE_CYCLES) ? IDLE_CYCLES : SETTLE_CYCLES;
    localparam int c_MAX_P = (c_MAX_A > RST_CYCLES) ? c_MAX_A : RST_CYCLES;
    localparam int c_CW    = $clog2(c_MAX_P + 1);

    localparam logic [c_CW-1:0] c_IDLE_LAST   = c_CW'(IDLE_CYCLES - 1);
    localparam logic [c_CW-1:0] c_SETTLE_LAST = c_CW'(SETTLE_CYCLES - 1);
    localparam logic [c_CW-1:0] c_RST_LAST    = c_CW'(RST_CYCLES - 1);
    localparam logic [c_CW-1:0] c_CNT_MAX     = {c_CW{1'b1}};

    typedef enum logic [2:0] {
        S_HOST        = 3'd0,
        S_WAIT_IDLE   = 3'd1,
        S_SWITCH_PFR  = 3'd2,
        S_PFR_OWN     = 3'd3,
        S_FLASH_RST   = 3'd4,
        S_SWITCH_HOST = 3'd5
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_cs_s1;
    logic              r_cs_s2;
    logic [c_CW-1:0]   r_idle_cnt;
    logic [c_CW-1:0]   w_idle_nxt;
    logic [c_CW-1:0]   r_cnt;
    logic [c_CW-1:0]   w_cnt_nxt;
    logic [c_CW-1:0]   w_idle_inc;
    logic [c_CW-1:0]   w_cnt_inc;
    logic              r_master_sel;
    logic              r_flash_rst_n;
    logic              r_grant;
    logic              w_timeout_nxt;

    assign w_idle_inc = (r_idle_cnt == c_CNT_MAX) ? r_idle_cnt : r_idle_cnt + c_CW'(1);
    assign w_cnt_inc  = (r_cnt == c_CNT_MAX) ? r_cnt : r_cnt + c_CW'(1);

`ifdef SPI_MUX_TIMEOUT_EN
    localparam int              c_TW      = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_TW-1:0] c_TO_LAST = c_TW'(TIMEOUT_CYCLES - 1);
    localparam logic [c_TW-1:0] c_TO_MAX  = {c_TW{1'b1}};

    logic [c_TW-1:0] r_to_cnt;
    logic [c_TW-1:0] w_to_nxt;
    logic            r_timeout;

    always_ff @(posedge iClk) begin
        if (iRst) begin
            r_to_cnt  <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_to_cnt  <= w_to_nxt;
            r_timeout <= w_timeout_nxt;
        end
    end

    assign oTimeout = r_timeout;
`else
    logic w_unused_timeout;
    assign w_unused_timeout = (TIMEOUT_CYCLES != 0) ^ w_timeout_nxt;
    assign oTimeout         = 1'b0;
`endif

    always_comb begin
        w_state_nxt   = r_state;
        w_idle_nxt    = r_idle_cnt;
        w_cnt_nxt     = r_cnt;
        w_timeout_nxt = 1'b0;
`ifdef SPI_MUX_TIMEOUT_EN
        w_to_nxt      = r_to_cnt;
`endif
        case (r_state)
            S_HOST: begin
                w_idle_nxt = '0;
                w_cnt_nxt  = '0;
`ifdef SPI_MUX_TIMEOUT_EN
                w_to_nxt   = '0;
`endif
                if (iPfrReq) begin
                    w_state_nxt = S_WAIT_IDLE;
                end
            end
            S_WAIT_IDLE: begin
                w_cnt_nxt = '0;
                // Release beats both the idle match and the forced takeover.
                if (!iPfrReq) begin
                    w_state_nxt = S_HOST;
                end else if (r_cs_s2 && (r_idle_cnt >= c_IDLE_LAST)) begin
                    w_state_nxt = S_SWITCH_PFR;
                    w_idle_nxt  = '0;
`ifdef SPI_MUX_TIMEOUT_EN
                end else if (r_to_cnt >= c_TO_LAST) begin
                    w_state_nxt   = S_SWITCH_PFR;
                    w_timeout_nxt = 1'b1;
`endif
                end else begin
                    w_idle_nxt = r_cs_s2 ? w_idle_inc : '0;
`ifdef SPI_MUX_TIMEOUT_EN
                    w_to_nxt   = (r_to_cnt == c_TO_MAX) ? r_to_cnt : r_to_cnt + c_TW'(1);
`endif
                end
            end
            S_SWITCH_PFR: begin
                if (r_cnt >= c_SETTLE_LAST) begin
                    w_state_nxt = S_PFR_OWN;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt   = w_cnt_inc;
                end
            end
            S_PFR_OWN: begin
                w_cnt_nxt = '0;
                if (!iPfrReq) begin
                    w_state_nxt = S_FLASH_RST;
                end
            end
            S_FLASH_RST: begin
                if (r_cnt >= c_RST_LAST) begin
                    w_state_nxt = S_SWITCH_HOST;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt   = w_cnt_inc;
                end
            end
            S_SWITCH_HOST: begin
                if (r_cnt >= c_SETTLE_LAST) begin
                    w_state_nxt = S_HOST;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt   = w_cnt_inc;
                end
            end
            default: begin
                w_state_nxt = S_HOST;
                w_cnt_nxt   = '0;
                w_idle_nxt  = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so they line up with oState.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            r_state       <= S_HOST;
            r_cs_s1       <= 1'b1;
            r_cs_s2       <= 1'b1;
            r_idle_cnt    <= '0;
            r_cnt         <= '0;
            r_master_sel  <= 1'b0;
            r_flash_rst_n <= 1'b1;
            r_grant       <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_cs_s1       <= iHostCs_n;
            r_cs_s2       <= r_cs_s1;
            r_idle_cnt    <= w_idle_nxt;
            r_cnt         <= w_cnt_nxt;
            r_master_sel  <= (w_state_nxt == S_SWITCH_PFR) ||
                             (w_state_nxt == S_PFR_OWN)    ||
                             (w_state_nxt == S_FLASH_RST);
            r_flash_rst_n <= (w_state_nxt != S_FLASH_RST);
            r_grant       <= (w_state_nxt == S_PFR_OWN);
        end
    end

    assign oMasterSel  = r_master_sel;
    assign oFlashRst_n = r_flash_rst_n;
    assign oGrant      = r_grant;
    assign oState      = r_state;

endmodule

`default_nettype wire

// File: tb/tb_spi_mux_handoff_ctl.sv
// ============================================================================
// Module   : tb_spi_mux_handoff_ctl
// Brief    : Randomized scoreboard bench for spi_mux_handoff_ctl.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_spi_mux_handoff_ctl;

    localparam int IDLE   = 16;
    localparam int SETTLE = 4;
    localparam int RSTC   = 8;
`ifdef SPI_MUX_TIMEOUT_EN
    localparam int TMO      = 64;
    localparam int HOLD_LOW = 100;
`else
    localparam int TMO      = 4096;
    localparam int HOLD_LOW = 10000;
`endif
    localparam int MAXC  = 20000;
    localparam int N_TXN = 30;

    logic       iClk = 1'b0;
    logic       iRst = 1'b1;
    logic       iPfrReq = 1'b0;
    logic       iHostCs_n = 1'b1;
    logic       oMasterSel;
    logic       oFlashRst_n;
    logic       oGrant;
    logic       oTimeout;
    logic [2:0] oState;

    always #5 iClk = ~iClk;

    spi_mux_handoff_ctl #(
        .IDLE_CYCLES   (IDLE),
        .SETTLE_CYCLES (SETTLE),
        .RST_CYCLES    (RSTC),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .iClk       (iClk),
        .iRst       (iRst),
        .iPfrReq    (iPfrReq),
        .iHostCs_n  (iHostCs_n),
        .oMasterSel (oMasterSel),
        .oFlashRst_n(oFlashRst_n),
        .oGrant     (oGrant),
        .oTimeout   (oTimeout),
        .oState     (oState)
    );

    // Input schedules: entry k is driven just after rising edge k.
    bit req_drv [MAXC];
    bit cs_drv  [MAXC];
    bit rst_drv [MAXC];

    typedef struct {
        int         cyc;
        logic [2:0] st;
        bit         to;
    } ev_t;
    ev_t exp_q[$];

    int n_checks = 0;
    int n_fail   = 0;
    int r_edge   = -1;
    int end_edge = 0;

    always @(posedge iClk) r_edge <= r_edge + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s at edge %0d: got %0h expected %0h", name, r_edge, act, req);
        end
    endtask

    function automatic void push(input int c, input logic [2:0] st, input bit to);
        ev_t e;
        e.cyc = c;
        e.st  = st;
        e.to  = to;
        exp_q.push_back(e);
    endfunction

    function automatic void fill_req(input int a, input int b);
        for (int k = a; k <= b; k++) req_drv[k] = 1'b1;
    endfunction

    // Edge at which IDLE consecutive synchronized-high CS samples have been
    // seen since entering WAIT_IDLE at edge w (sync delay: sample at edge e is
    // the value driven after edge e-3), or the forced takeover edge.
    function automatic void find_switch(input int w, input int limit, output int s, output bit to);
        int run;
        run = 0;
        s   = -1;
        to  = 1'b0;
        for (int e = w + 1; e <= limit; e++) begin
            run = cs_drv[e-3] ? run + 1 : 0;
            if (run >= IDLE) begin
                s = e;
                return;
            end
`ifdef SPI_MUX_TIMEOUT_EN
            if (e - w >= TMO) begin
                s  = e;
                to = 1'b1;
                return;
            end
`endif
        end
    endfunction

    function automatic logic exp_sel(input logic [2:0] st);
        return (st == 3'd2) || (st == 3'd3) || (st == 3'd4);
    endfunction

    // Monitor: pops an expected transition whenever the DUT changes state.
    logic [2:0] prev_st = 3'd0;
    logic [2:0] exp_st  = 3'd0;
    int         to_edge = -1;

    always @(negedge iClk) begin
        ev_t ev;
        if (oState !== prev_st) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_transition at edge %0d: got state %0d expected no change", r_edge, oState);
            end else begin
                ev = exp_q.pop_front();
                check("transition_edge", r_edge, ev.cyc);
                check("transition_state", {29'd0, oState}, {29'd0, ev.st});
                exp_st  = ev.st;
                to_edge = ev.to ? ev.cyc : -1;
            end
            prev_st = oState;
        end else if (exp_q.size() > 0 && exp_q[0].cyc < r_edge) begin
            ev = exp_q.pop_front();
            n_checks++;
            n_fail++;
            $display("FAIL missed_transition at edge %0d: got state %0d expected state %0d at edge %0d",
                     r_edge, oState, ev.st, ev.cyc);
            exp_st  = ev.st;
            to_edge = ev.to ? ev.cyc : -1;
        end
        check("oState",      {29'd0, oState},      {29'd0, exp_st});
        check("oMasterSel",  {31'd0, oMasterSel},  {31'd0, exp_sel(exp_st)});
        check("oFlashRst_n", {31'd0, oFlashRst_n}, {31'd0, (exp_st != 3'd4)});
        check("oGrant",      {31'd0, oGrant},      {31'd0, (exp_st == 3'd3)});
        check("oTimeout",    {31'd0, oTimeout},    {31'd0, (r_edge == to_edge)});
    end

    initial begin
        int h, w, s, d, a, p, c, gap, kind, n, j;
        bit to, rereq;

        for (int k = 0; k < MAXC; k++) begin
            req_drv[k] = 1'b0;
            cs_drv[k]  = 1'b1;
            rst_drv[k] = 1'b0;
        end
        for (int k = 0; k < 3; k++) rst_drv[k] = 1'b1;

        h     = 3;
        rereq = 1'b0;
        for (int t = 0; t < N_TXN + 2; t++) begin
            if (t == 0)           kind = 0;
            else if (t < N_TXN)   kind = $urandom_range(0, 2);
            else if (t == N_TXN)  kind = 3;
            else                  kind = 4;
            gap = (rereq || t == 0) ? 0 : $urandom_range(0, 5);
            w   = h + gap + 1;
            push(w, 3'd1, 1'b0);
            rereq = 1'b0;

            if (kind == 1) begin
                a = w + $urandom_range(1, 10);
                fill_req(w - 1, a - 2);
                push(a, 3'd0, 1'b0);
                h = a;
                continue;
            end
            if (kind == 2) begin
                c = w + $urandom_range(0, 3);
                n = $urandom_range(1, 6);
                for (int i = 0; i < n; i++) begin
                    j = $urandom_range(1, 2);
                    for (int k = 0; k < j; k++) cs_drv[c + k] = 1'b0;
                    c = c + j + $urandom_range(1, IDLE - 4);
                end
            end
            if (kind == 3) begin
                for (int k = w - 1; k < w + HOLD_LOW; k++) cs_drv[k] = 1'b0;
            end

            find_switch(w, (kind == 3) ? (w + HOLD_LOW - 1) : (w + 2000), s, to);
            if (s < 0) begin
                a = w + HOLD_LOW;
                fill_req(w - 1, a - 2);
                push(a, 3'd0, 1'b0);
                h = a;
                continue;
            end

            push(s, 3'd2, to);
            p = s + SETTLE;
            push(p, 3'd3, 1'b0);
            d = p + $urandom_range(0, 6) + 1;
            fill_req(w - 1, d - 2);
            push(d, 3'd4, 1'b0);
            if (kind == 4) begin
                rst_drv[d + 2] = 1'b1;
                push(d + 3, 3'd0, 1'b0);
                h = d + 3;
                break;
            end
            push(d + RSTC, 3'd5, 1'b0);
            h = d + RSTC + SETTLE;
            push(h, 3'd0, 1'b0);
            rereq = ($urandom_range(0, 1) == 1);
            if (rereq) begin
                j = $urandom_range(0, RSTC + SETTLE - 1);
                fill_req(d + j, h - 1);
            end
        end
        end_edge = h + 12;

        for (int k = 0; k <= end_edge; k++) begin
            @(posedge iClk);
            #1;
            iRst      = rst_drv[k];
            iPfrReq   = req_drv[k];
            iHostCs_n = cs_drv[k];
        end
        @(posedge iClk);
        #2;
        check("queue_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
